// File: rtl/boid_fb_pkg.sv
// Constants and types shared by the boid framebuffer writer and the VGA path.
package boid_fb_pkg;

    localparam int unsigned FB_WIDTH   = 320;
    localparam int unsigned FB_HEIGHT  = 480;
    localparam int unsigned ADDR_WIDTH = 20;
    localparam int unsigned COORD_W    = 9;

    typedef enum logic [2:0] {
        ST_INIT_CLEAR,
        ST_IDLE,
        ST_ERASE,
        ST_FETCH,
        ST_WAIT,
        ST_DRAW,
        ST_DONE
    } fw_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } boid_pos_t;

endpackage

// File: rtl/boid_square_scanner.sv
// Walks the pixels of one boid square (dx fastest, then dy) and gives the
// framebuffer address, clip flag and last-pixel flag for the current pixel.
module boid_square_scanner
    import boid_fb_pkg::*;
#(
    parameter int unsigned BOID_SIZE  = 2,
    parameter int unsigned FB_WIDTH   = boid_fb_pkg::FB_WIDTH,
    parameter int unsigned FB_HEIGHT  = boid_fb_pkg::FB_HEIGHT,
    parameter int unsigned ADDR_WIDTH = boid_fb_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step,
    input  logic [COORD_W-1:0]    base_x,
    input  logic [COORD_W-1:0]    base_y,
    output logic [ADDR_WIDTH-1:0] addr_c,
    output logic                  in_bounds_c,
    output logic                  last_c
);

    localparam int unsigned SW = (BOID_SIZE > 1) ? $clog2(BOID_SIZE) : 1;
    localparam int unsigned CW = COORD_W + 1;
    localparam logic [SW-1:0]         S_LAST     = SW'(BOID_SIZE - 1);
    localparam logic [CW-1:0]         COL_LIM    = CW'(FB_WIDTH);
    localparam logic [CW-1:0]         ROW_LIM    = CW'(FB_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(FB_WIDTH);

    logic [SW-1:0] dx_q, dx_d, dy_q, dy_d;
    logic [CW-1:0] col_c, row_c;

    // Counters wrap back to 0 after the last pixel, ready for the next square.
    always_comb begin
        dx_d   = dx_q;
        dy_d   = dy_q;
        last_c = (dx_q == S_LAST) && (dy_q == S_LAST);
        if (step) begin
            if (dx_q == S_LAST) begin
                dx_d = '0;
                dy_d = (dy_q == S_LAST) ? '0 : dy_q + SW'(1);
            end else begin
                dx_d = dx_q + SW'(1);
            end
        end
        col_c       = {1'b0, base_x} + CW'(dx_q);
        row_c       = {1'b0, base_y} + CW'(dy_q);
        in_bounds_c = (col_c < COL_LIM) && (row_c < ROW_LIM);
        addr_c      = ADDR_WIDTH'(col_c) + ROW_STRIDE * ADDR_WIDTH'(row_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

endmodule

// File: rtl/boid_frame_writer.sv
// Once per frame: erase every boid's previous square, then fetch and draw
// every boid's current square into the 1-bit framebuffer.
module boid_frame_writer
    import boid_fb_pkg::*;
#(
    parameter int unsigned NUM_BOIDS  = 16,
    parameter int unsigned BOID_SIZE  = 2,
    parameter int unsigned FB_WIDTH   = boid_fb_pkg::FB_WIDTH,
    parameter int unsigned FB_HEIGHT  = boid_fb_pkg::FB_HEIGHT,
    parameter int unsigned ADDR_WIDTH = boid_fb_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  screenEnd,
    output logic [((NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1)-1:0] pos_read_index,
    input  logic [COORD_W-1:0]    pos_read_x,
    input  logic [COORD_W-1:0]    pos_read_y,
    output logic                  fb_write_en,
    output logic [ADDR_WIDTH-1:0] fb_write_address,
    output logic                  fb_write_data,
    output logic                  busy,
    output logic [15:0]           frame_count,
    output logic                  overrun
);

    localparam int unsigned IDX_W = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1;
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_BOIDS - 1);
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT - 1);

    fw_state_e             state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d, pos_idx_q, pos_idx_d;
    logic [ADDR_WIDTH-1:0] clr_q, clr_d, fb_addr_q, fb_addr_d;
    logic                  fb_en_q, fb_en_d, fb_data_q, fb_data_d;
    logic                  prev_valid_q, prev_valid_d, busy_q, busy_d;
    logic                  overrun_q, overrun_d, screen_end_d_q, start_c;
    logic [15:0]           frame_count_q, frame_count_d;
    boid_pos_t             prev_q [NUM_BOIDS];
    boid_pos_t             prev_d [NUM_BOIDS];

    logic                  step_c, scan_in_bounds_c, scan_last_c;
    logic [ADDR_WIDTH-1:0] scan_addr_c;

    boid_square_scanner #(
        .BOID_SIZE  (BOID_SIZE),
        .FB_WIDTH   (FB_WIDTH),
        .FB_HEIGHT  (FB_HEIGHT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scanner (
        .clk         (clk),
        .reset       (reset),
        .step        (step_c),
        .base_x      (prev_q[idx_q].x),
        .base_y      (prev_q[idx_q].y),
        .addr_c      (scan_addr_c),
        .in_bounds_c (scan_in_bounds_c),
        .last_c      (scan_last_c)
    );

    assign start_c = screenEnd & ~screen_end_d_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pos_idx_d     = pos_idx_q;
        clr_d         = clr_q;
        fb_addr_d     = fb_addr_q;
        fb_en_d       = 1'b0;
        fb_data_d     = 1'b0;
        prev_valid_d  = prev_valid_q;
        frame_count_d = frame_count_q;
        prev_d        = prev_q;
        step_c        = 1'b0;
        overrun_d     = start_c && (state_q != ST_IDLE);

        case (state_q)
            ST_INIT_CLEAR: begin
                fb_en_d   = 1'b1;
                fb_addr_d = clr_q;
                clr_d     = clr_q + ADDR_WIDTH'(1);
                if (clr_q == CLR_LAST) begin
                    clr_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (start_c) begin
                    idx_d   = '0;
                    state_d = prev_valid_q ? ST_ERASE : ST_FETCH;
                end
            end
            ST_ERASE: begin
                step_c    = 1'b1;
                fb_en_d   = scan_in_bounds_c;
                fb_addr_d = scan_addr_c;
                if (scan_last_c) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_FETCH;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                prev_d[idx_q].x = pos_read_x;
                prev_d[idx_q].y = pos_read_y;
                state_d         = ST_DRAW;
            end
            ST_DRAW: begin
                step_c    = 1'b1;
                fb_en_d   = scan_in_bounds_c;
                fb_addr_d = scan_addr_c;
                fb_data_d = 1'b1;
                if (scan_last_c) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                frame_count_d = frame_count_q + 16'd1;
                prev_valid_d  = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_INIT_CLEAR;
        endcase

        // Position store sees the index during the FETCH cycle itself.
        if (state_d == ST_FETCH) begin
            pos_idx_d = idx_d;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_INIT_CLEAR;
            idx_q          <= '0;
            pos_idx_q      <= '0;
            clr_q          <= '0;
            fb_addr_q      <= '0;
            fb_en_q        <= 1'b0;
            fb_data_q      <= 1'b0;
            prev_valid_q   <= 1'b0;
            busy_q         <= 1'b1;
            overrun_q      <= 1'b0;
            frame_count_q  <= '0;
            screen_end_d_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            pos_idx_q      <= pos_idx_d;
            clr_q          <= clr_d;
            fb_addr_q      <= fb_addr_d;
            fb_en_q        <= fb_en_d;
            fb_data_q      <= fb_data_d;
            prev_valid_q   <= prev_valid_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            frame_count_q  <= frame_count_d;
            screen_end_d_q <= screenEnd;
        end
    end

    // Positions are only trusted once prev_valid is set, so no reset needed.
    always_ff @(posedge clk) begin
        prev_q <= prev_d;
    end

    // A write already registered is suppressed in the cycle reset is applied.
    assign fb_write_en      = fb_en_q & ~reset;
    assign fb_write_address = fb_addr_q;
    assign fb_write_data    = fb_data_q;
    assign pos_read_index   = pos_idx_q;
    assign busy             = busy_q;
    assign frame_count      = frame_count_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_boid_frame_writer.sv
// Directed bench for boid_frame_writer; a short framebuffer keeps clear sweeps small.
module tb_boid_frame_writer;

    localparam int unsigned FBW   = 320;
    localparam int unsigned FBH   = 24;
    localparam int unsigned AW    = 20;
    localparam int unsigned NB    = 16;
    localparam int unsigned SWEEP = FBW * FBH;

    logic          clk, reset, screenEnd;
    logic [3:0]    pos_read_index;
    logic [8:0]    pos_read_x, pos_read_y;
    logic          fb_write_en, fb_write_data, busy, overrun;
    logic [AW-1:0] fb_write_address;
    logic [15:0]   frame_count;

    logic [8:0]  mx [NB];
    logic [8:0]  my [NB];
    logic [20:0] wr_q[$];
    logic [20:0] exp_q[$];
    int          n_total = 0;
    int          n_bad   = 0;
    int          blen, ocnt;

    boid_frame_writer #(
        .NUM_BOIDS  (NB),
        .BOID_SIZE  (2),
        .FB_WIDTH   (FBW),
        .FB_HEIGHT  (FBH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .screenEnd        (screenEnd),
        .pos_read_index   (pos_read_index),
        .pos_read_x       (pos_read_x),
        .pos_read_y       (pos_read_y),
        .fb_write_en      (fb_write_en),
        .fb_write_address (fb_write_address),
        .fb_write_data    (fb_write_data),
        .busy             (busy),
        .frame_count      (frame_count),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    // Position store with one cycle of read latency.
    always @(posedge clk) begin
        pos_read_x <= mx[pos_read_index];
        pos_read_y <= my[pos_read_index];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] wr(input logic d, input int a);
        return {d, 20'(a)};
    endfunction

    task automatic check_writes(input string tag);
        int n;
        chk({tag, "_wr_cnt"}, wr_q.size(), exp_q.size());
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_wr"}, 32'(wr_q[i]), 32'(exp_q[i]));
        end
    endtask

    // Expects a full in-order sweep of zero writes ending with busy low.
    task automatic sweep_check(input string tag);
        int cnt = 0;
        int first_bad = -1;
        bit done = 0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (fb_write_en) begin
                if (first_bad < 0 && (fb_write_address != AW'(cnt) || fb_write_data))
                    first_bad = cnt;
                cnt++;
            end
            if (!busy) begin
                done = 1;
                break;
            end
        end
        chk({tag, "_clr_end"}, 32'(done), 1);
        chk({tag, "_clr_cnt"}, cnt, SWEEP);
        chk({tag, "_clr_order"}, first_bad, -1);
        chk({tag, "_clr_fc"}, frame_count, 0);
    endtask

    // One frame from a screenEnd rise; optional second rise glitch_at cycles later.
    task automatic run_frame(input string tag, input int glitch_at,
                             output int busy_len, output int ovr_len);
        bit done = 0;
        wr_q.delete();
        busy_len = 0;
        ovr_len  = 0;
        @(negedge clk);
        screenEnd = 1'b1;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge clk);
            if (n == 4) screenEnd = 1'b0;
            if (glitch_at > 0 && n == glitch_at) screenEnd = 1'b1;
            if (glitch_at > 0 && n == glitch_at + 4) screenEnd = 1'b0;
            if (overrun) ovr_len++;
            if (fb_write_en) wr_q.push_back({fb_write_data, fb_write_address});
            if (!busy) begin
                done = 1;
                break;
            end
            busy_len++;
        end
        screenEnd = 1'b0;
        chk({tag, "_end"}, 32'(done), 1);
    endtask

    initial begin
        bit found;
        clk       = 1'b0;
        reset     = 1'b1;
        screenEnd = 1'b0;
        for (int i = 0; i < NB; i++) begin
            mx[i] = 9'd400;
            my[i] = 9'd0;
        end

        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_we", fb_write_en, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_idx", pos_read_index, 0);
        reset = 1'b0;
        sweep_check("init");

        // First frame: nothing to erase.
        mx[0] = 9'd10; my[0] = 9'd20;
        exp_q = {wr(1, 6410), wr(1, 6411), wr(1, 6730), wr(1, 6731)};
        run_frame("f1", 0, blen, ocnt);
        chk("f1_len", blen, 97);
        chk("f1_ovr", ocnt, 0);
        check_writes("f1");
        chk("f1_fc", frame_count, 1);

        mx[0] = 9'd11;
        exp_q = {wr(0, 6410), wr(0, 6411), wr(0, 6730), wr(0, 6731),
                 wr(1, 6411), wr(1, 6412), wr(1, 6731), wr(1, 6732)};
        run_frame("f2", 0, blen, ocnt);
        chk("f2_len", blen, 161);
        check_writes("f2");
        chk("f2_fc", frame_count, 2);

        // Bottom-right corner: three of the four pixels are clipped.
        mx[0] = 9'd319; my[0] = 9'd23;
        exp_q = {wr(0, 6411), wr(0, 6412), wr(0, 6731), wr(0, 6732), wr(1, 7679)};
        run_frame("f3", 0, blen, ocnt);
        chk("f3_len", blen, 161);
        check_writes("f3");
        chk("f3_fc", frame_count, 3);

        // Second screenEnd rise 50 cycles into the frame.
        mx[0] = 9'd0; my[0] = 9'd0;
        exp_q = {wr(0, 7679), wr(1, 0), wr(1, 1), wr(1, 320), wr(1, 321)};
        run_frame("f4", 50, blen, ocnt);
        chk("f4_len", blen, 161);
        chk("f4_ovr", ocnt, 1);
        check_writes("f4");
        chk("f4_fc", frame_count, 4);

        // Reset while drawing.
        mx[0] = 9'd5; my[0] = 9'd2;
        found = 0;
        @(negedge clk);
        screenEnd = 1'b1;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge clk);
            if (n == 4) screenEnd = 1'b0;
            if (fb_write_en && fb_write_data) begin
                found = 1;
                break;
            end
        end
        screenEnd = 1'b0;
        chk("draw_seen", 32'(found), 1);
        reset = 1'b1;
        #1;
        chk("rst_draw_we", fb_write_en, 0);
        @(negedge clk);
        chk("rst_draw_fc", frame_count, 0);
        chk("rst_draw_busy", busy, 1);
        reset = 1'b0;
        sweep_check("rst");

        exp_q = {wr(1, 645), wr(1, 646), wr(1, 965), wr(1, 966)};
        run_frame("f6", 0, blen, ocnt);
        chk("f6_len", blen, 97);
        check_writes("f6");
        chk("f6_fc", frame_count, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
